uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares the single UART transmit FIFO write port (wr_uart / w_data / tx_full) between N_REQ on-chip byte producers, e.g. the echo path, a status reporter and a debug dumper. Each client uses a req/ack byte handshake. An optional lock input lets a client send a multi-byte message atomically, capped by MAX_BURST. The block sits between the clients and the uart unit.

Parameters:
N_REQ, 4, number of requesting clients (2..8)
DW, 8, byte width of w_data and of each client's data lane
MAX_BURST, 16, max consecutive bytes one locked client may write per grant (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req  in  N_REQ  client i has a byte on its lane
lock  in  N_REQ  client i requests to keep its grant after each byte
data  in  N_REQ*DW  client i's byte at [i*DW +: DW]
ack  out  N_REQ  one-hot pulse: client i's byte was written this cycle
grant  out  N_REQ  one-hot registered owner; all-zero when idle
tx_full  in  1  uart transmit FIFO full
wr_uart  out  1  write strobe to the uart transmit FIFO
w_data  out  DW  byte to the uart transmit FIFO
busy  out  1  high while a client owns the port

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state=IDLE, grant=0, ack=0, wr_uart=0, busy=0, rr pointer ptr=0, burst count=0. Reset asserted mid-burst clears all outputs immediately. No partial write completes.
- States: IDLE and OWN.
- IDLE:
  - If any req is high, pick the first asserted index scanning ptr, ptr+1, ..., wrapping mod N_REQ.
  - Register owner k, set grant=onehot(k), go to OWN, count=0.
  - No write happens in IDLE, so grant appears 1 cycle after req is sampled.
- OWN with owner k:
  - wr_uart = req[k] & ~tx_full, combinational.
  - w_data = data lane k, combinational.
  - ack[k] = wr_uart. All other ack bits are 0.
- Release (next state IDLE, grant cleared next cycle, ptr <= (k+1) mod N_REQ) on any of:
  - write with lock[k]=0 (single byte);
  - write with count+1 == MAX_BURST;
  - req[k]=0 (no write that cycle).
- Hold: a write with lock[k]=1 and count+1 < MAX_BURST increments count and keeps the grant.
- tx_full=1 while owning: no write, grant held, count unchanged, no timeout.
- Client rules:
  - Hold data stable while req is high and ack is low.
  - After ack, the client may present its next byte in the following cycle.
- Non-owners' req/lock are ignored until re-arbitration. Rotating ptr guarantees no starvation.
- Throughput: single-byte clients get 1 byte per 2 cycles. A locked burst of B bytes takes B+1 cycles with tx_full low.
- count width is clog2(MAX_BURST+1). It never wraps.

Decomposition:
- Shared package uart_arb_pkg holds:
  - state enum {IDLE, OWN};
  - default constants N_REQ_DEF=4, DW_DEF=8, MAX_BURST_DEF=16.
- One sub-module, rr_select: combinational rotating-priority picker.
  - Inputs: req[N_REQ], ptr.
  - Outputs: one-hot pick, index, any.

Test Plan:
- Single byte: req[2]=1, data lane2=0x41, lock=0 at cycle 0 -> grant=0100 at cycle 1 with wr_uart=1, w_data=0x41, ack[2]=1; grant=0 at cycle 2.
- Round robin: req=1111 held, lock=0, distinct bytes 0x10..0x13 -> writes in order 0x10, 0x11, 0x12, 0x13, 0x10, one every 2 cycles, one-hot acks.
- Burst cap: client 1 lock=1 with 20 bytes, client 3 req=1 -> exactly 16 consecutive writes from client 1; then client 3's byte; then client 1 resumes with byte 17.
- Back-pressure: tx_full=1 for 5 cycles mid-burst -> wr_uart=0 and ack=0 for those cycles, grant held; the same byte is written the first cycle tx_full=0.
- Request drop: owner with lock=1 drops req -> no write that cycle, grant=0 next cycle, ptr advances past owner.
- Reset mid-burst: reset asserted asynchronously during a write cycle -> grant, ack, wr_uart and busy go 0 before the next edge; after release, req=1111 grants client 0 first.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and default sizing for the UART transmit-port arbiter.
package uart_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  localparam int N_REQ_DEF     = 4;
  localparam int DW_DEF        = 8;
  localparam int MAX_BURST_DEF = 16;

endpackage

// File: rtl/uart_tx_arbiter_rr_select.sv
// Combinational rotating-priority picker: first asserted req at or after ptr, wrapping.
module rr_select
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] pick,
  output logic [IW-1:0]    index,
  output logic             any
);

  int cand;

  always_comb begin
    pick  = '0;
    index = '0;
    any   = 1'b0;
    cand  = 0;
    for (int o = 0; o < N_REQ; o++) begin
      cand = int'(ptr) + o;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!any && req[cand]) begin
        any         = 1'b1;
        index       = IW'(cand);
        pick[cand]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the UART transmit FIFO write port among N_REQ byte producers,
// with optional locked bursts capped at MAX_BURST bytes per grant.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int DW        = DW_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    lock,
  input  logic [N_REQ*DW-1:0] data,
  output logic [N_REQ-1:0]    ack,
  output logic [N_REQ-1:0]    grant,
  input  logic                tx_full,
  output logic                wr_uart,
  output logic [DW-1:0]       w_data,
  output logic                busy
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_e       state_q, state_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N_REQ-1:0] grant_q, grant_d;

  logic [N_REQ-1:0] pick;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic             rel;

  rr_select #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr_select (
    .req   (req),
    .ptr   (ptr_q),
    .pick  (pick),
    .index (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    wr_uart = 1'b0;
    ack     = '0;
    rel     = 1'b0;
    w_data  = data[int'(owner_q)*DW +: DW];

    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = OWN;
          owner_d = pick_idx;
          grant_d = pick;
          cnt_d   = '0;
        end
      end
      OWN: begin
        wr_uart       = req[owner_q] & ~tx_full;
        ack[owner_q]  = wr_uart;
        // Back-pressure simply stalls: grant and count stay put until the FIFO drains.
        if (!req[owner_q]) begin
          rel = 1'b1;
        end else if (wr_uart) begin
          if (!lock[owner_q] || (cnt_q + CW'(1)) == CW'(MAX_BURST)) rel = 1'b1;
          else cnt_d = cnt_q + CW'(1);
        end
        if (rel) begin
          state_d = IDLE;
          grant_d = '0;
          cnt_d   = '0;
          ptr_d   = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q == OWN);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level arbitration model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N-1:0]    lock;
  logic [N*DW-1:0] data;
  logic [N-1:0]    ack;
  logic [N-1:0]    grant;
  logic            tx_full;
  logic            wr_uart;
  logic [DW-1:0]   w_data;
  logic            busy;

  int total = 0;
  int bad   = 0;

  // Scripted client state for directed scenarios
  int         left[N];
  bit         lk[N];
  bit         stp[N];
  logic [7:0] base[N];
  int         sent[N];
  int         fl_lo, fl_hi;

  logic [N-1:0] g_log[64];
  logic [N-1:0] a_log[64];
  logic         w_log[64];
  logic         b_log[64];
  logic [7:0]   d_log[64];

  uart_tx_arbiter #(
    .N_REQ     (N),
    .DW        (DW),
    .MAX_BURST (MB)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .lock    (lock),
    .data    (data),
    .ack     (ack),
    .grant   (grant),
    .tx_full (tx_full),
    .wr_uart (wr_uart),
    .w_data  (w_data),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    reset   = 1'b1;
    req     = '0;
    lock    = '0;
    data    = '0;
    tx_full = 1'b0;
    for (int i = 0; i < N; i++) begin
      left[i] = 0; lk[i] = 1'b0; stp[i] = 1'b1; base[i] = 8'h00; sent[i] = 0;
    end
    fl_lo = -1;
    fl_hi = -2;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Scripted clients: each sends left[i] bytes, advancing on its ack; outputs logged per cycle.
  task automatic drive(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      for (int i = 0; i < N; i++) begin
        req[i]            = (left[i] > 0);
        lock[i]           = lk[i];
        data[i*DW +: DW]  = base[i] + 8'(stp[i] ? sent[i] : 0);
      end
      tx_full = (c >= fl_lo) && (c <= fl_hi);
      @(negedge clk);
      g_log[c] = grant; a_log[c] = ack; w_log[c] = wr_uart; b_log[c] = busy; d_log[c] = w_data;
      for (int i = 0; i < N; i++) begin
        if (ack[i]) begin
          sent[i]++;
          left[i]--;
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '1; lock = '1; data = '1; tx_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL reset_grant got=%b want=0000", grant); end
    total++; if (ack !== 4'b0000) begin bad++; $display("FAIL reset_ack got=%b want=0000", ack); end
    total++; if (wr_uart !== 1'b0) begin bad++; $display("FAIL reset_wr got=%b want=0", wr_uart); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    $display("reset: grant=%b ack=%b wr=%b busy=%b", grant, ack, wr_uart, busy);
    req = '0; lock = '0; data = '0;
    reset = 1'b0;
  endtask

  task automatic test_single_byte();
    do_reset();
    left[2] = 1; base[2] = 8'h41;
    drive(4);
    total++; if (g_log[0] !== 4'b0000 || w_log[0] !== 1'b0) begin bad++; $display("FAIL single_c0 got=g%b w%b want=g0000 w0", g_log[0], w_log[0]); end
    total++; if (g_log[1] !== 4'b0100) begin bad++; $display("FAIL single_grant got=%b want=0100", g_log[1]); end
    total++; if (w_log[1] !== 1'b1 || d_log[1] !== 8'h41) begin bad++; $display("FAIL single_write got=w%b d%h want=w1 d41", w_log[1], d_log[1]); end
    total++; if (a_log[1] !== 4'b0100 || b_log[1] !== 1'b1) begin bad++; $display("FAIL single_ack got=a%b b%b want=a0100 b1", a_log[1], b_log[1]); end
    total++; if (g_log[2] !== 4'b0000 || b_log[2] !== 1'b0) begin bad++; $display("FAIL single_release got=g%b b%b want=g0000 b0", g_log[2], b_log[2]); end
    $display("single_byte: c1 grant=%b data=%h ack=%b c2 grant=%b", g_log[1], d_log[1], a_log[1], g_log[2]);
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < N; i++) begin
      left[i] = 2; base[i] = 8'h10 + 8'(i); stp[i] = 1'b0;
    end
    drive(12);
    for (int j = 0; j < 5; j++) begin
      int cyc = 2 * j + 1;
      logic [7:0]   ed = 8'h10 + 8'(j % 4);
      logic [N-1:0] ea = 4'b0001 << (j % 4);
      total++;
      if (w_log[cyc] !== 1'b1 || d_log[cyc] !== ed || a_log[cyc] !== ea) begin
        bad++;
        $display("FAIL rr_write%0d got=w%b d%h a%b want=w1 d%h a%b", j, w_log[cyc], d_log[cyc], a_log[cyc], ed, ea);
      end
      total++;
      if (w_log[cyc-1] !== 1'b0) begin bad++; $display("FAIL rr_gap%0d got=%b want=0", j, w_log[cyc-1]); end
      $display("round_robin: write %0d cycle=%0d data=%h ack=%b", j, cyc, d_log[cyc], a_log[cyc]);
    end
  endtask

  task automatic test_burst_cap();
    do_reset();
    left[1] = 20; lk[1] = 1'b1; base[1] = 8'h80;
    left[3] = 1;  base[3] = 8'hC3;
    drive(24);
    for (int j = 0; j < MB; j++) begin
      total++;
      if (w_log[1+j] !== 1'b1 || d_log[1+j] !== 8'h80 + 8'(j) || a_log[1+j] !== 4'b0010) begin
        bad++;
        $display("FAIL burst_byte%0d got=w%b d%h a%b want=w1 d%h a0010", j, w_log[1+j], d_log[1+j], a_log[1+j], 8'h80 + 8'(j));
      end
    end
    total++; if (w_log[17] !== 1'b0 || g_log[17] !== 4'b0000) begin bad++; $display("FAIL burst_release got=w%b g%b want=w0 g0000", w_log[17], g_log[17]); end
    total++; if (w_log[18] !== 1'b1 || d_log[18] !== 8'hC3 || a_log[18] !== 4'b1000) begin bad++; $display("FAIL burst_other got=w%b d%h a%b want=w1 dc3 a1000", w_log[18], d_log[18], a_log[18]); end
    total++; if (w_log[20] !== 1'b1 || d_log[20] !== 8'h90 || a_log[20] !== 4'b0010) begin bad++; $display("FAIL burst_resume got=w%b d%h a%b want=w1 d90 a0010", w_log[20], d_log[20], a_log[20]); end
    $display("burst_cap: last_burst=%h other=%h resume=%h", d_log[16], d_log[18], d_log[20]);
  endtask

  task automatic test_back_pressure();
    do_reset();
    left[0] = 8; lk[0] = 1'b1; base[0] = 8'h20;
    fl_lo = 4; fl_hi = 8;
    drive(12);
    total++; if (w_log[3] !== 1'b1 || d_log[3] !== 8'h22) begin bad++; $display("FAIL bp_pre got=w%b d%h want=w1 d22", w_log[3], d_log[3]); end
    for (int c = 4; c <= 8; c++) begin
      total++;
      if (w_log[c] !== 1'b0 || a_log[c] !== 4'b0000 || g_log[c] !== 4'b0001) begin
        bad++;
        $display("FAIL bp_stall%0d got=w%b a%b g%b want=w0 a0000 g0001", c, w_log[c], a_log[c], g_log[c]);
      end
    end
    total++; if (w_log[9] !== 1'b1 || d_log[9] !== 8'h23) begin bad++; $display("FAIL bp_resume got=w%b d%h want=w1 d23", w_log[9], d_log[9]); end
    $display("back_pressure: stall grant=%b resume data=%h", g_log[6], d_log[9]);
  endtask

  task automatic test_req_drop();
    do_reset();
    left[0] = 3; lk[0] = 1'b1; base[0] = 8'h30;
    left[1] = 1; base[1] = 8'h51;
    drive(10);
    total++; if (w_log[3] !== 1'b1 || d_log[3] !== 8'h32) begin bad++; $display("FAIL drop_last got=w%b d%h want=w1 d32", w_log[3], d_log[3]); end
    total++; if (w_log[4] !== 1'b0 || g_log[4] !== 4'b0001) begin bad++; $display("FAIL drop_nowrite got=w%b g%b want=w0 g0001", w_log[4], g_log[4]); end
    total++; if (g_log[5] !== 4'b0000 || b_log[5] !== 1'b0) begin bad++; $display("FAIL drop_release got=g%b b%b want=g0000 b0", g_log[5], b_log[5]); end
    total++; if (g_log[6] !== 4'b0010 || w_log[6] !== 1'b1 || d_log[6] !== 8'h51) begin bad++; $display("FAIL drop_next got=g%b w%b d%h want=g0010 w1 d51", g_log[6], w_log[6], d_log[6]); end
    $display("req_drop: c4 grant=%b c5 grant=%b c6 grant=%b", g_log[4], g_log[5], g_log[6]);
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    left[0] = 10; lk[0] = 1'b1; base[0] = 8'h60;
    drive(3);
    total++; if (wr_uart !== 1'b1) begin bad++; $display("FAIL rstmid_pre got=%b want=1", wr_uart); end
    #2 reset = 1'b1;
    #1;
    total++; if (grant !== 4'b0000 || ack !== 4'b0000) begin bad++; $display("FAIL rstmid_ga got=g%b a%b want=g0000 a0000", grant, ack); end
    total++; if (wr_uart !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rstmid_wb got=w%b b%b want=w0 b0", wr_uart, busy); end
    @(posedge clk);
    #1 reset = 1'b0; req = 4'b1111; lock = '0;
    @(posedge clk);
    #1;
    total++; if (grant !== 4'b0001) begin bad++; $display("FAIL rstmid_first got=%b want=0001", grant); end
    $display("reset_mid_burst: after release grant=%b", grant);
    req = '0;
  endtask

  task automatic test_random();
    bit         m_own = 1'b0;
    int         m_k = 0, m_ptr = 0, m_cnt = 0;
    bit [N-1:0] rq = '0;
    logic [7:0] dt[N];
    int         nwr = 0;
    do_reset();
    for (int i = 0; i < N; i++) dt[i] = 8'h00;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [N-1:0] e_grant, e_ack;
      logic         e_wr;
      bit           rel;
      for (int i = 0; i < N; i++) begin
        if (!rq[i]) begin
          if ($urandom_range(0, 2) == 0) begin rq[i] = 1'b1; dt[i] = 8'($urandom); end
        end else if ($urandom_range(0, 19) == 0) begin
          rq[i] = 1'b0;
        end
        req[i]           = rq[i];
        lock[i]          = ($urandom_range(0, 3) != 0);
        data[i*DW +: DW] = dt[i];
      end
      tx_full = ($urandom_range(0, 4) == 0);
      @(negedge clk);
      e_grant = m_own ? (4'b0001 << m_k) : 4'b0000;
      e_wr    = m_own && req[m_k] && !tx_full;
      e_ack   = e_wr ? (4'b0001 << m_k) : 4'b0000;
      total++; if (grant !== e_grant) begin bad++; $display("FAIL rnd_grant cyc=%0d got=%b want=%b", cyc, grant, e_grant); end
      total++; if (busy !== m_own) begin bad++; $display("FAIL rnd_busy cyc=%0d got=%b want=%b", cyc, busy, m_own); end
      total++; if (wr_uart !== e_wr) begin bad++; $display("FAIL rnd_wr cyc=%0d got=%b want=%b", cyc, wr_uart, e_wr); end
      total++; if (ack !== e_ack) begin bad++; $display("FAIL rnd_ack cyc=%0d got=%b want=%b", cyc, ack, e_ack); end
      if (e_wr) begin
        nwr++;
        total++; if (w_data !== dt[m_k]) begin bad++; $display("FAIL rnd_data cyc=%0d got=%h want=%h", cyc, w_data, dt[m_k]); end
      end
      // Arbitration rules applied at the clock edge
      rel = 1'b0;
      if (!m_own) begin
        for (int o = 0; o < N; o++) begin
          int idx = (m_ptr + o) % N;
          if (req[idx]) begin m_own = 1'b1; m_k = idx; m_cnt = 0; break; end
        end
      end else if (!req[m_k]) begin
        rel = 1'b1;
      end else if (e_wr) begin
        m_cnt++;
        if (!lock[m_k] || m_cnt == MB) rel = 1'b1;
      end
      if (rel) begin m_own = 1'b0; m_ptr = (m_k + 1) % N; m_cnt = 0; end
      for (int i = 0; i < N; i++) begin
        if (ack[i]) begin
          if ($urandom_range(0, 1) == 0) dt[i] = 8'($urandom);
          else rq[i] = 1'b0;
        end
      end
      @(posedge clk);
      #1;
    end
    $display("random: cycles=3000 writes=%0d", nwr);
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_round_robin();
    test_burst_cap();
    test_back_pressure();
    test_req_drop();
    test_reset_mid_burst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
